// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
//   Shared types and default raster timing for the video scanout path.
//   pixel_t            : 24-bit RGB pixel {R[23:16], G[15:8], B[7:0]}
//   DEF_* localparams  : default 800x480 timing (active, porches, sync widths)
// -----------------------------------------------------------------------------
package video_pkg;

    typedef logic [23:0] pixel_t;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 40;
    localparam int unsigned DEF_H_SYNC   = 48;
    localparam int unsigned DEF_H_BP     = 88;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 13;
    localparam int unsigned DEF_V_SYNC   = 3;
    localparam int unsigned DEF_V_BP     = 32;

    localparam int unsigned DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/video_scanout_pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
//   Synchronous show-ahead FIFO of pixel_t entries.
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (empties the FIFO)
//   flush    in   synchronous empty; overrides push/pop this cycle
//   push     in   write wr_data; accepted when not full or when popping
//   wr_data  in   pixel to write
//   pop      in   remove head; ignored when empty
//   rd_data  out  current head (valid when !empty)
//   empty    out  no entries
//   full     out  DEPTH entries
//   count    out  number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module pixel_fifo
    import video_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  pixel_t                     wr_data,
    input  logic                       pop,
    output pixel_t                     rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    pixel_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            wr_en_s;
    logic            rd_en_s;

    // Pointer and occupancy update; a full FIFO still takes a write when the
    // head leaves in the same cycle.
    always_comb begin
        rd_en_s  = pop && (count_q != {CW{1'b0}});
        wr_en_s  = push && ((count_q != CNT_DEPTH) || rd_en_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_en_s  = 1'b0;
            rd_en_s  = 1'b0;
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == {CW{1'b0}});
    assign full    = (count_q == CNT_DEPTH);
    assign count   = count_q;

endmodule

// File: rtl/video_scanout.sv
// -----------------------------------------------------------------------------
// video_scanout
//   Consumer end of the pixel stream: buffers incoming RGB pixels in a small
//   FIFO and emits them with raster timing, one pixel per in_clk. Pulses
//   out_next_frame so the upstream source restarts at pixel (0,0).
//   in_clk          in   pixel clock
//   in_reset        in   synchronous active-high reset
//   in_pixel_data   in   24-bit RGB pixel
//   in_pixel_valid  in   pixel present this cycle (never back-pressured)
//   in_pixel_ready  out  source may send one pixel next cycle
//   out_next_frame  out  one-cycle restart pulse for the source
//   out_rgb         out  display pixel, 0 outside the active region
//   out_hsync       out  horizontal sync (polarity HSYNC_POL)
//   out_vsync       out  vertical sync (polarity VSYNC_POL)
//   out_de          out  data enable
//   out_underflow   out  sticky: FIFO empty when a pixel was due
//   out_overflow    out  sticky: valid pixel dropped because FIFO was full
// -----------------------------------------------------------------------------
module video_scanout
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter logic        HSYNC_POL  = 1'b0,
    parameter logic        VSYNC_POL  = 1'b0,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         in_clk,
    input  logic         in_reset,
    input  logic [23:0]  in_pixel_data,
    input  logic         in_pixel_valid,
    output logic         in_pixel_ready,
    output logic         out_next_frame,
    output logic [23:0]  out_rgb,
    output logic         out_hsync,
    output logic         out_vsync,
    output logic         out_de,
    output logic         out_underflow,
    output logic         out_overflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [HW-1:0] H_ONE     = HW'(1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);

    localparam logic [VW-1:0] V_ONE     = VW'(1);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

    localparam logic [CW:0]   READY_LIMIT = (CW + 1)'(FIFO_DEPTH);

    // Raster position and registered outputs.
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          next_frame_q, next_frame_d;
    pixel_t        rgb_q, rgb_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          ready_q, ready_d;
    logic          underflow_q, underflow_d;
    logic          overflow_q, overflow_d;

    // Combinational decode.
    logic          active_s;
    logic          hs_win_s;
    logic          vs_win_s;
    logic          frame_start_s;
    logic          flush_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          push_acc_s;
    logic          drop_s;
    logic [CW-1:0] fill_next_s;
    logic [CW:0]   demand_s;

    // FIFO interface.
    pixel_t        fifo_rd_data_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [CW-1:0] fifo_count_s;

    pixel_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (in_clk),
        .reset   (in_reset),
        .flush   (flush_s),
        .push    (fifo_push_s),
        .wr_data (in_pixel_data),
        .pop     (fifo_pop_s),
        .rd_data (fifo_rd_data_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .count   (fifo_count_s)
    );

    // Horizontal/vertical counter advance.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = {HW{1'b0}};
            if (v_q == V_LAST) begin
                v_d = {VW{1'b0}};
            end else begin
                v_d = v_q + V_ONE;
            end
        end else begin
            h_d = h_q + H_ONE;
            v_d = v_q;
        end
    end

    // Timing windows and FIFO control for the current counter state.
    always_comb begin
        active_s      = (h_q < H_ACT) && (v_q < V_ACT);
        hs_win_s      = (h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI);
        vs_win_s      = (v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI);
        frame_start_s = (h_q == {HW{1'b0}}) && (v_q == V_ACT);
        // The restart pulse cycle flushes the FIFO and discards any pixel
        // that was already in flight, so the source starts cleanly at (0,0).
        flush_s       = next_frame_q;
        fifo_pop_s    = active_s && !fifo_empty_s;
        fifo_push_s   = in_pixel_valid && !flush_s;
        push_acc_s    = fifo_push_s && (!fifo_full_s || fifo_pop_s);
        drop_s        = fifo_push_s && fifo_full_s && !fifo_pop_s;
        if (flush_s) begin
            fill_next_s = {CW{1'b0}};
        end else begin
            fill_next_s = fifo_count_s + CW'(push_acc_s) - CW'(fifo_pop_s);
        end
        // Next cycle's ready: next fill plus the pixel our current ready may
        // still bring in must leave room for one more.
        demand_s      = {1'b0, fill_next_s} + (CW + 1)'(ready_q);
    end

    // Next values of the registered outputs and sticky flags.
    always_comb begin
        next_frame_d = frame_start_s;
        de_d         = active_s;
        hsync_d      = hs_win_s ? HSYNC_POL : ~HSYNC_POL;
        vsync_d      = vs_win_s ? VSYNC_POL : ~VSYNC_POL;
        rgb_d        = 24'h000000;
        underflow_d  = underflow_q;
        overflow_d   = overflow_q | drop_s;
        if (active_s) begin
            if (fifo_empty_s) begin
                rgb_d       = 24'h000000;
                underflow_d = 1'b1;
            end else begin
                rgb_d       = fifo_rd_data_s;
            end
        end else begin
            rgb_d = 24'h000000;
        end
        if (next_frame_d) begin
            ready_d = 1'b0;
        end else begin
            ready_d = (demand_s < READY_LIMIT);
        end
    end

    // State and output registers; reset returns to the first blank line.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            h_q          <= {HW{1'b0}};
            v_q          <= V_ACT;
            next_frame_q <= 1'b0;
            rgb_q        <= 24'h000000;
            de_q         <= 1'b0;
            hsync_q      <= ~HSYNC_POL;
            vsync_q      <= ~VSYNC_POL;
            ready_q      <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            next_frame_q <= next_frame_d;
            rgb_q        <= rgb_d;
            de_q         <= de_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            ready_q      <= ready_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
        end
    end

    assign in_pixel_ready = ready_q;
    assign out_next_frame = next_frame_q;
    assign out_rgb        = rgb_q;
    assign out_de         = de_q;
    assign out_hsync      = hsync_q;
    assign out_vsync      = vsync_q;
    assign out_underflow  = underflow_q;
    assign out_overflow   = overflow_q;

endmodule

// File: tb/tb_video_scanout.sv
// -----------------------------------------------------------------------------
// tb_video_scanout
//   Directed bench for video_scanout with small timing (H 8/2/2/2, V 4/1/1/1,
//   FIFO depth 4, active-low syncs). A source model answers ready one cycle
//   later with ramp data and restarts on out_next_frame.
// -----------------------------------------------------------------------------
module tb_video_scanout;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int HA = 8;
    localparam int VA = 4;

    logic        in_clk;
    logic        in_reset;
    logic [23:0] in_pixel_data;
    logic        in_pixel_valid;
    logic        in_pixel_ready;
    logic        out_next_frame;
    logic [23:0] out_rgb;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_de;
    logic        out_underflow;
    logic        out_overflow;

    int checks = 0;
    int errors = 0;

    // Raster model: counters of this cycle and of the previous one.
    int cur_h, cur_v, prev_h, prev_v;
    bit cur_ok, prev_ok;
    bit exp_de, exp_hs, exp_vs, exp_nf;

    // Source model state.
    int pix_cnt;
    int src_limit;
    int pushes;
    bit prev_ready;

    video_scanout #(
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (2),
        .H_BP       (2),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (1),
        .HSYNC_POL  (1'b0),
        .VSYNC_POL  (1'b0),
        .FIFO_DEPTH (4)
    ) dut (
        .in_clk         (in_clk),
        .in_reset       (in_reset),
        .in_pixel_data  (in_pixel_data),
        .in_pixel_valid (in_pixel_valid),
        .in_pixel_ready (in_pixel_ready),
        .out_next_frame (out_next_frame),
        .out_rgb        (out_rgb),
        .out_hsync      (out_hsync),
        .out_vsync      (out_vsync),
        .out_de         (out_de),
        .out_underflow  (out_underflow),
        .out_overflow   (out_overflow)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // One clock: advance the raster model, derive expected timing outputs,
    // then drive the source for the new cycle.
    task automatic tick();
        logic rst_edge;
        rst_edge = in_reset;
        @(posedge in_clk);
        #1;
        prev_h  = cur_h;
        prev_v  = cur_v;
        prev_ok = cur_ok;
        if (rst_edge) begin
            cur_h   = 0;
            cur_v   = VA;
            cur_ok  = 1'b1;
            prev_ok = 1'b0;
        end else if (cur_ok) begin
            if (cur_h == HT - 1) begin
                cur_h = 0;
                cur_v = (cur_v == VT - 1) ? 0 : cur_v + 1;
            end else begin
                cur_h = cur_h + 1;
            end
        end
        exp_de = prev_ok && (prev_h < HA) && (prev_v < VA);
        exp_hs = !(prev_ok && (prev_h >= 10) && (prev_h < 12));
        exp_vs = !(prev_ok && (prev_v == 5));
        exp_nf = prev_ok && (prev_h == 0) && (prev_v == VA);
        if (in_reset) begin
            in_pixel_valid = 1'b0;
            in_pixel_data  = 24'h000000;
            prev_ready     = 1'b0;
            pix_cnt        = 0;
        end else begin
            if (out_next_frame) begin
                pix_cnt = 0;
                pushes  = 0;
            end
            in_pixel_valid = prev_ready && (pix_cnt < src_limit);
            in_pixel_data  = 24'(pix_cnt);
            if (in_pixel_valid && !out_next_frame) begin
                pix_cnt = pix_cnt + 1;
                pushes  = pushes + 1;
            end
            prev_ready = in_pixel_ready;
        end
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (out_rgb !== 24'h000000 || out_de !== 1'b0) begin
                errors++;
                $display("FAIL reset_rgb_de: got rgb=%h de=%b want rgb=000000 de=0", out_rgb, out_de);
            end
            checks++;
            if (out_next_frame !== 1'b0 || in_pixel_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_nf_ready: got nf=%b ready=%b want 0 0", out_next_frame, in_pixel_ready);
            end
            checks++;
            if (out_hsync !== 1'b1 || out_vsync !== 1'b1) begin
                errors++;
                $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", out_hsync, out_vsync);
            end
            checks++;
            if (out_underflow !== 1'b0 || out_overflow !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags: got uf=%b ov=%b want 0 0", out_underflow, out_overflow);
            end
        end
    endtask

    // Release reset and run one complete frame with ramp data.
    task automatic test_frame();
        int k;
        int de_cnt;
        bit fill_checked;
        logic [23:0] exp_rgb;
        k = 0;
        de_cnt = 0;
        fill_checked = 1'b0;
        in_reset = 1'b0;
        checks++;
        if (out_next_frame !== 1'b0) begin
            errors++;
            $display("FAIL frame_nf_cycle1: got %b want 0", out_next_frame);
        end
        for (int n = 0; n < VT * HT; n++) begin
            tick();
            checks++;
            if (out_next_frame !== exp_nf) begin
                errors++;
                $display("FAIL frame_nf: h=%0d v=%0d got %b want %b", prev_h, prev_v, out_next_frame, exp_nf);
            end
            checks++;
            if (out_de !== exp_de) begin
                errors++;
                $display("FAIL frame_de: h=%0d v=%0d got %b want %b", prev_h, prev_v, out_de, exp_de);
            end
            checks++;
            if (out_hsync !== exp_hs || out_vsync !== exp_vs) begin
                errors++;
                $display("FAIL frame_sync: h=%0d v=%0d got hs=%b vs=%b want hs=%b vs=%b",
                         prev_h, prev_v, out_hsync, out_vsync, exp_hs, exp_vs);
            end
            exp_rgb = exp_de ? 24'(k) : 24'h000000;
            if (exp_de) k = k + 1;
            checks++;
            if (out_rgb !== exp_rgb) begin
                errors++;
                $display("FAIL frame_rgb: h=%0d v=%0d got %h want %h", prev_h, prev_v, out_rgb, exp_rgb);
            end
            checks++;
            if (out_underflow !== 1'b0 || out_overflow !== 1'b0) begin
                errors++;
                $display("FAIL frame_flags: got uf=%b ov=%b want 0 0", out_underflow, out_overflow);
            end
            if (out_de === 1'b1) de_cnt = de_cnt + 1;
            if (cur_h == 0 && cur_v == 0 && !fill_checked) begin
                fill_checked = 1'b1;
                checks++;
                if (pushes != 4 || in_pixel_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_prefill: got pushes=%0d ready=%b want 4 0", pushes, in_pixel_ready);
                end
            end
        end
        checks++;
        if (de_cnt != 32) begin
            errors++;
            $display("FAIL frame_de_count: got %0d want 32", de_cnt);
        end
    endtask

    // Source stops after pixel 4 of the next frame.
    task automatic test_underflow();
        int k;
        bit exp_uf;
        logic [23:0] exp_rgb;
        k = 0;
        exp_uf = 1'b0;
        src_limit = 5;
        for (int n = 0; n < VT * HT; n++) begin
            tick();
            exp_rgb = 24'h000000;
            if (exp_de) begin
                if (k < 5) begin
                    exp_rgb = 24'(k);
                end else begin
                    exp_uf = 1'b1;
                end
                k = k + 1;
            end
            checks++;
            if (out_rgb !== exp_rgb) begin
                errors++;
                $display("FAIL underflow_rgb: h=%0d v=%0d got %h want %h", prev_h, prev_v, out_rgb, exp_rgb);
            end
            checks++;
            if (out_underflow !== exp_uf) begin
                errors++;
                $display("FAIL underflow_flag: h=%0d v=%0d got %b want %b", prev_h, prev_v, out_underflow, exp_uf);
            end
        end
    endtask

    // One-cycle reset at h=3, v=1.
    task automatic test_mid_reset();
        src_limit = 1000;
        for (int n = 0; n < 200; n++) begin
            if (cur_h == 3 && cur_v == 1) break;
            tick();
        end
        checks++;
        if (out_underflow !== 1'b1) begin
            errors++;
            $display("FAIL midreset_sticky: got uf=%b want 1", out_underflow);
        end
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        checks++;
        if (out_rgb !== 24'h000000 || out_de !== 1'b0 || out_hsync !== 1'b1 || out_vsync !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: got rgb=%h de=%b hs=%b vs=%b want 000000 0 1 1",
                     out_rgb, out_de, out_hsync, out_vsync);
        end
        checks++;
        if (out_underflow !== 1'b0 || out_overflow !== 1'b0 || in_pixel_ready !== 1'b0 || out_next_frame !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: got uf=%b ov=%b ready=%b nf=%b want 0 0 0 0",
                     out_underflow, out_overflow, in_pixel_ready, out_next_frame);
        end
        tick();
        checks++;
        if (out_next_frame !== 1'b1) begin
            errors++;
            $display("FAIL midreset_nf_pulse: got %b want 1", out_next_frame);
        end
        tick();
        checks++;
        if (out_next_frame !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nf_end: got %b want 0", out_next_frame);
        end
    endtask

    // Extra valid while the FIFO is full during vertical blanking.
    task automatic test_overflow();
        int k;
        int de_cnt;
        logic [23:0] exp_rgb;
        k = 0;
        de_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            if (cur_h == 0 && cur_v == 5) break;
            tick();
        end
        checks++;
        if (in_pixel_ready !== 1'b0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pre: got ready=%b ov=%b want 0 0", in_pixel_ready, out_overflow);
        end
        in_pixel_valid = 1'b1;
        in_pixel_data  = 24'hABCDEF;
        tick();
        checks++;
        if (out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b want 1", out_overflow);
        end
        for (int n = 0; n < 200; n++) begin
            if (cur_h == 0 && cur_v == VA) break;
            tick();
            if (out_de === 1'b1) de_cnt = de_cnt + 1;
            if (exp_de && k < 8) begin
                exp_rgb = 24'(k);
                checks++;
                if (out_rgb !== exp_rgb) begin
                    errors++;
                    $display("FAIL overflow_rgb: index %0d got %h want %h", k, out_rgb, exp_rgb);
                end
            end
            if (exp_de) k = k + 1;
        end
        checks++;
        if (out_overflow !== 1'b1 || out_underflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sticky: got ov=%b uf=%b want 1 0", out_overflow, out_underflow);
        end
        checks++;
        if (de_cnt != 32) begin
            errors++;
            $display("FAIL overflow_de_count: got %0d want 32", de_cnt);
        end
    endtask

    initial begin
        in_reset       = 1'b1;
        in_pixel_valid = 1'b0;
        in_pixel_data  = 24'h000000;
        cur_h          = 0;
        cur_v          = 0;
        prev_h         = 0;
        prev_v         = 0;
        cur_ok         = 1'b0;
        prev_ok        = 1'b0;
        pix_cnt        = 0;
        src_limit      = 1000;
        pushes         = 0;
        prev_ready     = 1'b0;
        test_reset();
        test_frame();
        test_underflow();
        test_mid_reset();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
